// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-requester memory port arbiter.
// This package holds the FSM encoding, the wait-counter width and the round-robin pick helper.
package mem_port_arbiter_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int CNT_W = 8;

    // If both requesters are asking, the one that did not own the port last time wins.
    function automatic logic rr_pick(input logic r0, input logic r1, input logic last);
        if (r0 && r1) return ~last;
        return r1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_mux.sv
// Two-input selector that sits in front of the memory port.
// It is used for both the address path and the write-data path.
module mem_port_arbiter_mux #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sel,
    output logic [W-1:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between instruction fetch (0) and data load/store (1).
// state | meaning
// IDLE  | no owner; arbitrate among pending requests
// BUSY  | owner's access on the memory port; waiting for mem_ready or timeout
// DONE  | ack pulse to owner; grant released on the next edge
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    input  logic          we0,
    input  logic          we1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          ack0,
    output logic          ack1,
    output logic          err,
    output logic [DW-1:0] rdata,
    output logic          sel,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic             pick;

    assign pick   = rr_pick(req0, req1, last);
    assign mem_en = (state == ST_BUSY);
    assign mem_we = mem_en & (sel ? we1 : we0);

    mem_port_arbiter_mux #(.W(AW)) u_addr_mux (
        .a   (addr0),
        .b   (addr1),
        .sel (sel),
        .y   (mem_addr)
    );

    mem_port_arbiter_mux #(.W(DW)) u_wdata_mux (
        .a   (wdata0),
        .b   (wdata1),
        .sel (sel),
        .y   (mem_wdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            sel   <= 1'b0;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            ack0  <= 1'b0;
            ack1  <= 1'b0;
            err   <= 1'b0;
            rdata <= '0;
            cnt   <= '0;
            last  <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        sel   <= pick;
                        gnt0  <= ~pick;
                        gnt1  <= pick;
                        last  <= pick;
                        cnt   <= '0;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // A ready arriving on the timeout cycle still counts as success.
                    if (mem_ready) begin
                        rdata <= mem_rdata;
                        err   <= 1'b0;
                        ack0  <= ~sel;
                        ack1  <= sel;
                        state <= ST_DONE;
                    end else if (cnt == CNT_LAST) begin
                        rdata <= '0;
                        err   <= 1'b1;
                        ack0  <= ~sel;
                        ack1  <= sel;
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
